// File: rtl/cic_decimator.sv
// cic_decimator: dual-channel (I/Q) N-stage CIC decimator by R = 2**LOG2_DECIMATION with a one-cycle data_valid strobe
module cic_decimator #(
  parameter int INPUT_WIDTH = 12,
  parameter int OUTPUT_WIDTH = 12,
  parameter int STAGES = 3,
  parameter int LOG2_DECIMATION = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [INPUT_WIDTH-1:0]  sinewave_in,
  input  logic signed [INPUT_WIDTH-1:0]  cosinewave_in,
  output logic signed [OUTPUT_WIDTH-1:0] sinewave_out,
  output logic signed [OUTPUT_WIDTH-1:0] cosinewave_out,
  output logic                           data_valid
);
  localparam int ACC_WIDTH = INPUT_WIDTH + STAGES * LOG2_DECIMATION;
  logic signed [ACC_WIDTH-1:0] r_int_s [STAGES];
  logic signed [ACC_WIDTH-1:0] r_int_c [STAGES];
  logic signed [ACC_WIDTH-1:0] r_comb_s [STAGES];
  logic signed [ACC_WIDTH-1:0] r_comb_c [STAGES];
  logic signed [ACC_WIDTH-1:0] r_dly_s [STAGES];
  logic signed [ACC_WIDTH-1:0] r_dly_c [STAGES];
  logic signed [ACC_WIDTH-1:0] r_decim_s, r_decim_c;
  logic signed [ACC_WIDTH-1:0] w_x_s [STAGES];
  logic signed [ACC_WIDTH-1:0] w_x_c [STAGES];
  logic signed [ACC_WIDTH-1:0] w_ext_s, w_ext_c;
  logic [LOG2_DECIMATION-1:0]  r_cnt;
  logic [STAGES:0]             r_en;
  assign w_ext_s = {{(ACC_WIDTH-INPUT_WIDTH){sinewave_in[INPUT_WIDTH-1]}}, sinewave_in};
  assign w_ext_c = {{(ACC_WIDTH-INPUT_WIDTH){cosinewave_in[INPUT_WIDTH-1]}}, cosinewave_in};
  // Each comb stage differentiates the previous stage's output; the first one takes the decimated sample.
  always_comb begin
    w_x_s[0] = r_decim_s;
    w_x_c[0] = r_decim_c;
    for (int k = 1; k < STAGES; k++) begin
      w_x_s[k] = r_comb_s[k-1];
      w_x_c[k] = r_comb_c[k-1];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_int_s[k] <= '0;
        r_int_c[k] <= '0;
        r_comb_s[k] <= '0;
        r_comb_c[k] <= '0;
        r_dly_s[k] <= '0;
        r_dly_c[k] <= '0;
      end
      r_decim_s <= '0;
      r_decim_c <= '0;
      r_cnt <= '0;
      r_en <= '0;
      sinewave_out <= '0;
      cosinewave_out <= '0;
      data_valid <= 1'b0;
    end else begin
      r_int_s[0] <= r_int_s[0] + w_ext_s;
      r_int_c[0] <= r_int_c[0] + w_ext_c;
      for (int k = 1; k < STAGES; k++) begin
        r_int_s[k] <= r_int_s[k] + r_int_s[k-1];
        r_int_c[k] <= r_int_c[k] + r_int_c[k-1];
      end
      r_cnt <= r_cnt + LOG2_DECIMATION'(1);
      r_en <= {r_en[STAGES-1:0], &r_cnt};
      if (&r_cnt) begin
        r_decim_s <= r_int_s[STAGES-1];
        r_decim_c <= r_int_c[STAGES-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        if (r_en[k]) begin
          r_comb_s[k] <= w_x_s[k] - r_dly_s[k];
          r_comb_c[k] <= w_x_c[k] - r_dly_c[k];
          r_dly_s[k] <= w_x_s[k];
          r_dly_c[k] <= w_x_c[k];
        end
      end
      data_valid <= r_en[STAGES];
      if (r_en[STAGES]) begin
        sinewave_out <= r_comb_s[STAGES-1][ACC_WIDTH-1 -: OUTPUT_WIDTH];
        cosinewave_out <= r_comb_c[STAGES-1][ACC_WIDTH-1 -: OUTPUT_WIDTH];
      end
    end
  end
endmodule
